chipselect_ctrl: RTL and testbench
==================================

Name: chipselect_ctrl

Overview:
Multi-channel SPI chip-select controller. It sits between the SPI transfer state machine and the CS output pins, and drives one of NUM_CS chip selects. In auto mode it applies programmable setup, hold and inter-frame gap timing. In manual mode the user drives the pins directly.

Parameters:
NUM_CS, 4, number of chip-select outputs (1..16)
SEL_W, 2, width of select index; must satisfy 2^SEL_W >= NUM_CS
DLY_W, 4, width of setup/hold/gap cycle counts
ACTIVE_HIGH_MASK, 0, bit i = 1 means cs[i] is active-high; 0 means active-low

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  block enable (ctrl register bit 15)
cs_auto  in  1  1 = auto mode (FSM-timed), 0 = manual mode
cs_manual  in  NUM_CS  raw pin levels driven in manual mode
select  in  SEL_W  target channel index in auto mode
cs_pull_low  in  1  transfer FSM request: begin frame (assert CS)
cs_pull_high  in  1  transfer FSM request: end frame (deassert CS)
setup_cycles  in  DLY_W  cycles from CS assert to cs_ready
hold_cycles  in  DLY_W  cycles from cs_pull_high to CS deassert
gap_cycles  in  DLY_W  minimum CS-inactive cycles before the next frame
cs  out  NUM_CS  chip-select pins
cs_ready  out  1  high while the frame is open and transfer may shift
cs_done  out  1  one-cycle pulse when the gap completes
busy  out  1  high in any state other than IDLE
sel_err  out  1  one-cycle pulse when a frame is requested with select >= NUM_CS

Behaviour:
- All outputs are registered. Inactive level of cs[i] = ~ACTIVE_HIGH_MASK[i].
- Reset (reset_n low, async): cs = all inactive; state = IDLE; counter = 0; cs_ready = busy = cs_done = sel_err = 0.
- enable low (synchronous, checked next edge): same values as reset. Enable takes priority over mode and requests.
- Manual mode (cs_auto = 0, enable = 1): cs <= cs_manual every cycle; state forced to IDLE; cs_ready = cs_done = 0.
- cs_auto dropping mid-frame aborts the frame. Next edge: IDLE, manual levels driven, no cs_done.
- Auto mode FSM states: IDLE, SETUP, ACTIVE, HOLD, GAP.
  - IDLE: cs all inactive.
    - On cs_pull_low with select < NUM_CS: latch select into sel_q, assert cs[sel_q] next edge, load counter = setup_cycles, go to SETUP.
    - On cs_pull_low with select >= NUM_CS: pulse sel_err, stay in IDLE, cs unchanged.
    - cs_pull_high in IDLE is ignored. If pull_low and pull_high are both high in IDLE, pull_low wins.
  - SETUP: cs[sel_q] asserted. Counter decrements each cycle; leave when counter = 0, so SETUP lasts max(setup_cycles,1) cycles. Next state ACTIVE. cs_pull_high in SETUP is latched and honoured on entry to ACTIVE.
  - ACTIVE: cs_ready = 1. On cs_pull_high (or latched request): load counter = hold_cycles, cs_ready <= 0, go to HOLD. cs_pull_low is ignored.
  - HOLD: cs[sel_q] stays asserted for hold_cycles cycles; hold_cycles = 0 means zero HOLD cycles. Then deassert cs[sel_q], load counter = gap_cycles, go to GAP.
  - GAP: cs all inactive for gap_cycles cycles (0 allowed). On exit pulse cs_done for 1 cycle and return to IDLE.
- Requests arriving during GAP are dropped. The transfer FSM must wait for cs_done or !busy.
- Only one cs bit is ever active in auto mode. Non-selected channels stay inactive at all times.
- Counters saturate at 0 and never wrap. select and the delay inputs are sampled only at the transitions listed above; changing them mid-frame has no effect on the current frame.
- Minimum frame with all delays 0 and pull_high held: assert edge -> SETUP 1 -> ACTIVE 1 -> deassert. cs active for 2 cycles.

Test Plan:
- Reset: drive reset_n low mid-ACTIVE with NUM_CS=4, ACTIVE_HIGH_MASK=4'b0100 -> cs=4'b1011 asynchronously; busy=0; cs_ready=0.
- Auto frame: select=2, setup=3, hold=2, gap=4, pull_low pulse, pull_high 10 cycles later -> cs[2] active; cs_ready rises 3 cycles after assert; cs[2] goes inactive 2 cycles after pull_high; cs_done pulses 4 cycles after deassert; other bits stay inactive.
- Zero delays: setup=hold=gap=0, pull_low and pull_high asserted together in ACTIVE -> cs active exactly 2 cycles; cs_done on the cycle after deassert.
- Invalid select: NUM_CS=3, select=3, pull_low -> sel_err 1-cycle pulse; cs unchanged; busy=0.
- Manual mode and abort: cs_auto=0, cs_manual=4'b0110 -> cs=4'b0110 next edge. Drop cs_auto during HOLD -> cs=cs_manual next edge, IDLE, no cs_done.
- Enable drop: enable=0 during SETUP -> all cs inactive next edge, IDLE. Re-enable and issue a new frame -> normal timing.

Source files
------------

// File: rtl/chipselect_ctrl_if.sv
// Chip-select controller bus: control/timing inputs from the transfer FSM and
// register block, pin/status outputs back from the controller.
interface chipselect_ctrl_if #(
  parameter int NUM_CS = 4,
  parameter int SEL_W  = 2,
  parameter int DLY_W  = 4
);
  logic              enable;
  logic              cs_auto;
  logic [NUM_CS-1:0] cs_manual;
  logic [SEL_W-1:0]  select;
  logic              cs_pull_low;
  logic              cs_pull_high;
  logic [DLY_W-1:0]  setup_cycles;
  logic [DLY_W-1:0]  hold_cycles;
  logic [DLY_W-1:0]  gap_cycles;
  logic [NUM_CS-1:0] cs;
  logic              cs_ready;
  logic              cs_done;
  logic              busy;
  logic              sel_err;

  modport master (
    output enable, cs_auto, cs_manual, select, cs_pull_low, cs_pull_high,
           setup_cycles, hold_cycles, gap_cycles,
    input  cs, cs_ready, cs_done, busy, sel_err
  );

  modport slave (
    input  enable, cs_auto, cs_manual, select, cs_pull_low, cs_pull_high,
           setup_cycles, hold_cycles, gap_cycles,
    output cs, cs_ready, cs_done, busy, sel_err
  );
endinterface

// File: rtl/chipselect_ctrl.sv
// Multi-channel SPI chip-select controller. Auto mode runs a
// SETUP/ACTIVE/HOLD/GAP frame on one selected channel; manual mode passes raw
// pin levels through. Every output comes straight from a flop.
module chipselect_ctrl #(
  parameter int                NUM_CS           = 4,
  parameter int                SEL_W            = 2,
  parameter int                DLY_W            = 4,
  parameter logic [NUM_CS-1:0] ACTIVE_HIGH_MASK = '0
) (
  input logic             clk,
  input logic             reset_n,
  chipselect_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, GAP} state_t;

  localparam logic [NUM_CS-1:0] CS_OFF = ~ACTIVE_HIGH_MASK;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              pend_q, pend_d;   // pull_high seen during SETUP
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              sel_ok;
  logic              cnt_last;

  // Pin pattern with only channel s driven to its active level.
  function automatic logic [NUM_CS-1:0] assert_pat(input logic [SEL_W-1:0] s);
    logic [NUM_CS-1:0] p;
    p = CS_OFF;
    for (int i = 0; i < NUM_CS; i++)
      if (32'(s) == 32'(i)) p[i] = ~CS_OFF[i];
    return p;
  endfunction

  assign sel_ok   = (32'(bus.select) < 32'(NUM_CS));
  // Phases of length 0 and 1 both end on the first counted edge, so a
  // count of 0 behaves like 1 and the counter never has to wrap.
  assign cnt_last = (cnt_q <= DLY_W'(1));

  // Next-state and next-output logic; enable beats mode, mode beats requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cs_d    = cs_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      cs_d    = CS_OFF;
      ready_d = 1'b0;
    end else if (!bus.cs_auto) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      cs_d    = bus.cs_manual;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cs_d    = CS_OFF;
          ready_d = 1'b0;
          pend_d  = 1'b0;
          if (bus.cs_pull_low) begin
            if (sel_ok) begin
              sel_d   = bus.select;
              cnt_d   = bus.setup_cycles;
              cs_d    = assert_pat(bus.select);
              state_d = SETUP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        SETUP: begin
          if (bus.cs_pull_high) pend_d = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            ready_d = 1'b1;
            state_d = ACTIVE;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        ACTIVE: begin
          if (bus.cs_pull_high || pend_q) begin
            pend_d  = 1'b0;
            ready_d = 1'b0;
            if (bus.hold_cycles == '0) begin
              cs_d    = CS_OFF;
              cnt_d   = bus.gap_cycles;
              state_d = GAP;
            end else begin
              cnt_d   = bus.hold_cycles;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cs_d    = CS_OFF;
            cnt_d   = bus.gap_cycles;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        GAP: begin
          if (cnt_last) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      cs_q    <= CS_OFF;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cs_q    <= cs_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.cs       = cs_q;
  assign bus.cs_ready = ready_q;
  assign bus.cs_done  = done_q;
  assign bus.busy     = busy_q;
  assign bus.sel_err  = err_q;

endmodule

// File: tb/tb_chipselect_ctrl.sv
// Bench for chipselect_ctrl: a 4-channel instance (channel 2 active-high) and
// a 3-channel all-active-low instance share one stimulus stream. A timeline
// model (absolute edge numbers for ready/deassert/done) predicts every output.
module tb_chipselect_ctrl;

  localparam int INF = 32'h3fffffff;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic       en, auto_m, pl, ph;
  logic [3:0] man, su, ho, ga;
  logic [1:0] sel;

  chipselect_ctrl_if #(.NUM_CS(4), .SEL_W(2), .DLY_W(4)) bus4 ();
  chipselect_ctrl_if #(.NUM_CS(3), .SEL_W(2), .DLY_W(4)) bus3 ();

  assign bus4.enable = en;        assign bus3.enable = en;
  assign bus4.cs_auto = auto_m;   assign bus3.cs_auto = auto_m;
  assign bus4.cs_manual = man;    assign bus3.cs_manual = man[2:0];
  assign bus4.select = sel;       assign bus3.select = sel;
  assign bus4.cs_pull_low = pl;   assign bus3.cs_pull_low = pl;
  assign bus4.cs_pull_high = ph;  assign bus3.cs_pull_high = ph;
  assign bus4.setup_cycles = su;  assign bus3.setup_cycles = su;
  assign bus4.hold_cycles = ho;   assign bus3.hold_cycles = ho;
  assign bus4.gap_cycles = ga;    assign bus3.gap_cycles = ga;

  chipselect_ctrl #(.NUM_CS(4), .SEL_W(2), .DLY_W(4), .ACTIVE_HIGH_MASK(4'b0100)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  chipselect_ctrl #(.NUM_CS(3), .SEL_W(2), .DLY_W(4), .ACTIVE_HIGH_MASK(3'b000)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

  typedef struct packed {
    logic       frame;
    logic       want;
    logic [1:0] sel;
    int         ready_at;
    int         deassert_at;
    int         done_at;
    logic [3:0] cs;
    logic       ready;
    logic       done;
    logic       busy;
    logic       err;
  } mdl_t;

  mdl_t m4, m3;
  int   n = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic int max1(input logic [3:0] v);
    return (v == 4'd0) ? 1 : int'(v);
  endfunction

  function automatic mdl_t mreset(input logic [3:0] off);
    mdl_t r;
    r = '0;
    r.cs = off;
    r.ready_at = INF; r.deassert_at = INF; r.done_at = INF;
    return r;
  endfunction

  // One clock edge numbered n, in terms of when the frame's milestones fall.
  function automatic mdl_t step(input mdl_t m, input int ncs, input logic [3:0] off);
    mdl_t r;
    r = m;
    r.done = 1'b0;
    r.err  = 1'b0;
    if (!en || !auto_m) begin
      r = mreset(off);
      r.cs = en ? man : off;
      return r;
    end
    if (!r.frame) begin
      if (pl) begin
        if (int'(sel) >= ncs) r.err = 1'b1;
        else begin
          r.frame = 1'b1; r.sel = sel; r.want = 1'b0;
          r.ready_at = n + max1(su);
          r.deassert_at = INF; r.done_at = INF;
        end
      end
    end else begin
      if (n <= r.ready_at) begin
        if (ph) r.want = 1'b1;
      end else if (r.deassert_at == INF && (ph || r.want)) begin
        r.want = 1'b0;
        r.deassert_at = n + int'(ho);
      end
      if (n == r.deassert_at) r.done_at = n + max1(ga);
      if (n == r.done_at) begin
        r.done = 1'b1;
        r.frame = 1'b0;
      end
    end
    r.cs = off;
    if (r.frame && n < r.deassert_at) r.cs[r.sel] = ~off[r.sel];
    r.ready = r.frame && (n >= r.ready_at) && (r.deassert_at == INF);
    r.busy  = r.frame;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m4.cs",    16'(bus4.cs),       16'(m4.cs));
    chk("m4.ready", 16'(bus4.cs_ready), 16'(m4.ready));
    chk("m4.done",  16'(bus4.cs_done),  16'(m4.done));
    chk("m4.busy",  16'(bus4.busy),     16'(m4.busy));
    chk("m4.err",   16'(bus4.sel_err),  16'(m4.err));
    chk("m3.cs",    16'(bus3.cs),       16'(m3.cs[2:0]));
    chk("m3.ready", 16'(bus3.cs_ready), 16'(m3.ready));
    chk("m3.done",  16'(bus3.cs_done),  16'(m3.done));
    chk("m3.busy",  16'(bus3.busy),     16'(m3.busy));
    chk("m3.err",   16'(bus3.sel_err),  16'(m3.err));
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    if (reset_n) begin
      m4 = step(m4, 4, 4'b1011);
      m3 = step(m3, 3, 4'b1111);
    end
    #1;
    check_model();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    en = 1'b1; auto_m = 1'b1; pl = 1'b0; ph = 1'b0;
    man = 4'h0; su = 4'd0; ho = 4'd0; ga = 4'd0; sel = 2'd0;
    m4 = mreset(4'b1011);
    m3 = mreset(4'b1111);

    // Power-on reset
    #2 reset_n = 1'b0;
    #1;
    chk("rst.cs4",   16'(bus4.cs),   16'h000b);
    chk("rst.cs3",   16'(bus3.cs),   16'h0007);
    chk("rst.busy",  16'(bus4.busy), 16'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    ticks(2);

    // Auto frame: select 2, setup 3, hold 2, gap 4
    sel = 2'd2; su = 4'd3; ho = 4'd2; ga = 4'd4; pl = 1'b1;
    tick();
    pl = 1'b0;
    chk("af.cs_assert", 16'(bus4.cs), 16'h000f);
    chk("af.ready0", 16'(bus4.cs_ready), 16'h0);
    ticks(2);
    chk("af.ready_early", 16'(bus4.cs_ready), 16'h0);
    tick();
    chk("af.ready_rise", 16'(bus4.cs_ready), 16'h1);
    ticks(6);
    ph = 1'b1;
    tick();
    ph = 1'b0;
    chk("af.ready_fall", 16'(bus4.cs_ready), 16'h0);
    tick();
    chk("af.hold_cs", 16'(bus4.cs), 16'h000f);
    tick();
    chk("af.deassert", 16'(bus4.cs), 16'h000b);
    ticks(3);
    chk("af.done_early", 16'(bus4.cs_done), 16'h0);
    tick();
    chk("af.done", 16'(bus4.cs_done), 16'h1);
    tick();
    chk("af.idle_busy", 16'(bus4.busy), 16'h0);

    // Zero delays, both requests held
    sel = 2'd1; su = 4'd0; ho = 4'd0; ga = 4'd0; pl = 1'b1; ph = 1'b1;
    tick();
    chk("zd.cs1", 16'(bus4.cs), 16'h0009);
    tick();
    chk("zd.cs2", 16'(bus4.cs), 16'h0009);
    chk("zd.ready", 16'(bus4.cs_ready), 16'h1);
    tick();
    pl = 1'b0; ph = 1'b0;
    chk("zd.deassert", 16'(bus4.cs), 16'h000b);
    tick();
    chk("zd.done", 16'(bus4.cs_done), 16'h1);
    tick();

    // Invalid select on the 3-channel instance
    sel = 2'd3; pl = 1'b1;
    tick();
    pl = 1'b0;
    chk("se.err", 16'(bus3.sel_err), 16'h1);
    chk("se.busy", 16'(bus3.busy), 16'h0);
    chk("se.cs", 16'(bus3.cs), 16'h0007);
    tick();
    chk("se.err_pulse", 16'(bus3.sel_err), 16'h0);
    ph = 1'b1;
    ticks(2);
    ph = 1'b0;
    ticks(2);

    // Manual mode
    auto_m = 1'b0; man = 4'b0110;
    tick();
    chk("mm.cs4", 16'(bus4.cs), 16'h0006);
    chk("mm.cs3", 16'(bus3.cs), 16'h0006);

    // Abort during HOLD
    auto_m = 1'b1; sel = 2'd0; su = 4'd1; ho = 4'd5; ga = 4'd2; pl = 1'b1;
    tick();
    pl = 1'b0;
    tick();
    ph = 1'b1;
    tick();
    ph = 1'b0;
    tick();
    chk("ab.hold_cs", 16'(bus4.cs), 16'h000a);
    auto_m = 1'b0;
    tick();
    chk("ab.cs_manual", 16'(bus4.cs), 16'h0006);
    chk("ab.busy", 16'(bus4.busy), 16'h0);
    tick();
    chk("ab.no_done", 16'(bus4.cs_done), 16'h0);

    // Enable drop during SETUP, then a fresh frame
    auto_m = 1'b1; sel = 2'd3; su = 4'd4; pl = 1'b1;
    tick();
    pl = 1'b0;
    tick();
    en = 1'b0;
    tick();
    chk("en.cs", 16'(bus4.cs), 16'h000b);
    chk("en.busy", 16'(bus4.busy), 16'h0);
    en = 1'b1; su = 4'd2; ho = 4'd1; ga = 4'd1; pl = 1'b1;
    tick();
    pl = 1'b0;
    chk("en.assert", 16'(bus4.cs), 16'h0003);
    ticks(2);
    chk("en.ready", 16'(bus4.cs_ready), 16'h1);
    ph = 1'b1;
    tick();
    ph = 1'b0;
    tick();
    chk("en.deassert", 16'(bus4.cs), 16'h000b);
    tick();
    chk("en.done", 16'(bus4.cs_done), 16'h1);

    // Randomized traffic against the timeline model
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom % 64) != 0;
      auto_m = ($urandom % 40) != 0;
      man    = 4'($urandom);
      sel    = 2'($urandom);
      pl     = ($urandom % 6) == 0;
      ph     = ($urandom % 5) == 0;
      su     = (($urandom % 8) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      ho     = 4'($urandom_range(0, 4));
      ga     = 4'($urandom_range(0, 5));
      tick();
    end

    // Asynchronous reset in the middle of ACTIVE
    en = 1'b1; auto_m = 1'b1; pl = 1'b0; ph = 1'b0;
    ticks(40);
    sel = 2'd1; su = 4'd1; ho = 4'd3; ga = 4'd1; pl = 1'b1;
    tick();
    pl = 1'b0;
    ticks(2);
    chk("ar.pre_ready", 16'(bus4.cs_ready), 16'h1);
    #1 reset_n = 1'b0;
    #1;
    m4 = mreset(4'b1011);
    m3 = mreset(4'b1111);
    chk("ar.cs", 16'(bus4.cs), 16'h000b);
    chk("ar.busy", 16'(bus4.busy), 16'h0);
    chk("ar.ready", 16'(bus4.cs_ready), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
